// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch bus between ifu_fetch (master) and the memory (slave).
// req is held high until ack; addr is stable for the whole request.
interface ifu_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds PC and IR, fetches over a req/ack handshake,
// waits in EXEC for the retire strobe (pc_wr), then loads the next PC.
// Optional feature macro: IFU_JR_EN (npc_op=11 selects the jr target rs_data;
// when undefined, npc_op=11 falls back to pc+4).
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  npc_op,
   input  logic        pc_wr,
   input  logic [31:0] rs_data,
   ifu_fetch_if.master imem,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t      state;
   logic        req;
   logic [31:0] npc;
   logic [31:0] br_off;

   assign imem.req  = req;
   assign imem.addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

`ifdef IFU_JR_EN
   logic unused_rs;
   assign unused_rs = ^rs_data[1:0];
`else
   logic unused_rs;
   assign unused_rs = ^rs_data;
`endif

   // Next-PC select; only consumed in the cycle pc_wr is accepted in EXEC.
   always_comb begin
      npc = pc_plus4;
      case (npc_op)
         2'b01:   npc = pc_plus4 + br_off;
         2'b10:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
`ifdef IFU_JR_EN
         2'b11:   npc = {rs_data[31:2], 2'b00};
`else
         2'b11:   npc = pc_plus4;
`endif
         default: npc = pc_plus4;
      endcase
   end

   // Fetch FSM with registered req/IR/valid/PC; reset overrides any in-flight ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         req         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
               req   <= 1'b1;
            end
            FETCH: begin
               if (imem.ack) begin
                  instr       <= imem.rdata;
                  instr_valid <= 1'b1;
                  req         <= 1'b0;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               if (pc_wr) begin
                  pc          <= npc;
                  instr_valid <= 1'b0;
                  req         <= 1'b1;
                  state       <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule
